// File: rtl/ob_table_drain.sv
// Order-book table drain: walks a best-first price table, removing quantity up to a limit price.
// Optional OB_TABLE_DRAIN_EARLY_EXIT_EN ends the scan early once nothing more can match.
package bcd_pkg;
  // Four BCD digits; BCD ordering matches unsigned binary ordering, so prices compare directly.
  typedef logic [15:0] price_t;
endpackage

package ob_pkg;
  typedef logic [7:0]  quantity_t;
  typedef logic [15:0] accum_quantity_t;
  typedef struct packed {
    bcd_pkg::price_t price;
    quantity_t       quantity;
  } table_t;
endpackage

module ob_table_drain #(
  parameter int N      = 16,
  parameter bit is_ask = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_vld,
  input  bcd_pkg::price_t                     cmd_price,
  input  ob_pkg::accum_quantity_t             cmd_quantity,
  input  ob_pkg::table_t [N:0]                tbl_r,
  input  logic [N:0]                          tbl_vld_r,
  output logic                                tbl_wr_en,
  output logic [$clog2(N+1)-1:0]              tbl_wr_idx,
  output logic                                tbl_wr_inv,
  output ob_pkg::quantity_t                   tbl_wr_quantity,
  output logic                                fill_vld,
  output bcd_pkg::price_t                     fill_price,
  output ob_pkg::quantity_t                   fill_quantity,
  output logic                                rsp_vld,
  output ob_pkg::accum_quantity_t             rsp_filled,
  output ob_pkg::accum_quantity_t             rsp_remaining,
  output logic                                busy_w
);
  localparam int IW = $clog2(N+1);
  localparam int QW = $bits(ob_pkg::quantity_t);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  ob_pkg::accum_quantity_t rem_q, rem_d;
  ob_pkg::accum_quantity_t filled_q, filled_d;
  bcd_pkg::price_t         price_q, price_d;
  logic                    rsp_vld_q, rsp_vld_d;
  ob_pkg::accum_quantity_t rsp_filled_q, rsp_filled_d;
  ob_pkg::accum_quantity_t rsp_remaining_q, rsp_remaining_d;
`ifdef OB_TABLE_DRAIN_EARLY_EXIT_EN
  logic                    stop_q, stop_d;
`endif

  ob_pkg::table_t          ent;
  ob_pkg::accum_quantity_t ent_qty;
  ob_pkg::accum_quantity_t ded;
  logic                    price_ok;
  logic                    exit_now;
  logic                    match;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    rem_d           = rem_q;
    filled_d        = filled_q;
    price_d         = price_q;
    tbl_wr_en       = 1'b0;
    tbl_wr_idx      = '0;
    tbl_wr_inv      = 1'b0;
    tbl_wr_quantity = '0;
    fill_vld        = 1'b0;
    fill_price      = '0;
    fill_quantity   = '0;

    ent      = tbl_r[idx_q];
    ent_qty  = ob_pkg::accum_quantity_t'(ent.quantity);
    price_ok = is_ask ? (price_q >= ent.price) : (price_q <= ent.price);
    ded      = (rem_q < ent_qty) ? rem_q : ent_qty;
`ifdef OB_TABLE_DRAIN_EARLY_EXIT_EN
    stop_d   = stop_q;
    // Exit is decided from registered status, so the exiting cycle examines nothing.
    exit_now = (rem_q == '0) | stop_q;
`else
    exit_now = 1'b0;
`endif
    match = (state_q == SCAN) & tbl_vld_r[idx_q] & price_ok & (rem_q != '0) & ~exit_now;

    case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          price_d  = cmd_price;
          rem_d    = cmd_quantity;
          idx_d    = '0;
          filled_d = '0;
`ifdef OB_TABLE_DRAIN_EARLY_EXIT_EN
          stop_d   = 1'b0;
`endif
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          tbl_wr_en       = 1'b1;
          tbl_wr_idx      = idx_q;
          tbl_wr_inv      = (ded == ent_qty);
          tbl_wr_quantity = ent.quantity - ded[QW-1:0];
          fill_vld        = 1'b1;
          fill_price      = ent.price;
          fill_quantity   = ded[QW-1:0];
          rem_d           = rem_q - ded;
          filled_d        = filled_q + ded;
        end
`ifdef OB_TABLE_DRAIN_EARLY_EXIT_EN
        // Table is sorted best-first: a valid entry out of price means no later one can match.
        if (tbl_vld_r[idx_q] & ~price_ok)
          stop_d = 1'b1;
`endif
        idx_d = idx_q + IW'(1);
        if ((idx_q == IW'(N - 1)) || exit_now)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rsp_vld_d       = (state_d == DONE);
    rsp_filled_d    = rsp_vld_d ? filled_d : '0;
    rsp_remaining_d = rsp_vld_d ? rem_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      rem_q           <= '0;
      filled_q        <= '0;
      price_q         <= '0;
      rsp_vld_q       <= 1'b0;
      rsp_filled_q    <= '0;
      rsp_remaining_q <= '0;
`ifdef OB_TABLE_DRAIN_EARLY_EXIT_EN
      stop_q          <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      rem_q           <= rem_d;
      filled_q        <= filled_d;
      price_q         <= price_d;
      rsp_vld_q       <= rsp_vld_d;
      rsp_filled_q    <= rsp_filled_d;
      rsp_remaining_q <= rsp_remaining_d;
`ifdef OB_TABLE_DRAIN_EARLY_EXIT_EN
      stop_q          <= stop_d;
`endif
    end
  end

  assign rsp_vld       = rsp_vld_q;
  assign rsp_filled    = rsp_filled_q;
  assign rsp_remaining = rsp_remaining_q;
  assign busy_w        = (state_q != IDLE);

endmodule

// File: doc/ob_table_drain.md
OB_TABLE_DRAIN -- requirements
Module: ob_table_drain

Interface
REQ-001 SHALL have parameter N, default 16, number of table entries scanned (indices 0..N-1).
REQ-002 SHALL have parameter is_ask, default 1; 1 = ask table, match when cmd_price >= entry price; 0 = bid table, match when cmd_price <= entry price.
REQ-003 SHALL have port clk  input  1  clock; the block uses one clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_vld  input  1  drain command strobe.
REQ-006 SHALL have port cmd_price  input  bcd_pkg::price_t  command limit price.
REQ-007 SHALL have port cmd_quantity  input  ob_pkg::accum_quantity_t  quantity to remove.
REQ-008 SHALL have port tbl_r  input  ob_pkg::table_t [N:0]  table state, sorted best-first; entry N is never scanned.
REQ-009 SHALL have port tbl_vld_r  input  [N:0]  per-entry valid.
REQ-010 SHALL have port tbl_wr_en  output  1  table write-back strobe.
REQ-011 SHALL have port tbl_wr_idx  output  $clog2(N+1)  entry being written.
REQ-012 SHALL have port tbl_wr_inv  output  1  1 = invalidate the entry, 0 = update its quantity.
REQ-013 SHALL have port tbl_wr_quantity  output  ob_pkg::quantity_t  new entry quantity when tbl_wr_inv=0.
REQ-014 SHALL have port fill_vld, fill_price, fill_quantity  output  1/price_t/quantity_t  per-entry fill record.
REQ-015 SHALL have port rsp_vld  output  1  command-complete strobe.
REQ-016 SHALL have ports rsp_filled and rsp_remaining  output  accum_quantity_t  total filled and unfilled quantity.
REQ-017 SHALL have port busy_w  output  1  high in every state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, SCAN and DONE, with a scan index idx and a remaining register rem.
REQ-019 In IDLE with cmd_vld=1, SHALL latch price and quantity, set rem=cmd_quantity, set idx=0, clear the filled accumulator, and enter SCAN on the next cycle.
REQ-020 SHALL ignore cmd_vld while busy_w=1; the command is dropped, with no state change.
REQ-021 In SCAN, each cycle SHALL examine entry idx; match = tbl_vld_r[idx] & price compare & (rem != 0).
REQ-022 On a match, the deduction d SHALL be min(rem, entry quantity), computed at accum_quantity_t width with no overflow.
REQ-023 On a match, in the same cycle the block SHALL assert tbl_wr_en, set tbl_wr_idx=idx, set tbl_wr_inv=(d==entry quantity), and set tbl_wr_quantity=entry quantity-d (0 when invalidating).
REQ-024 On a match, the block SHALL assert fill_vld with fill_price=entry price and fill_quantity=d; rem-=d and filled+=d at the clock edge.
REQ-025 With no match, the block SHALL leave tbl_wr_en and fill_vld at 0.
REQ-026 SHALL increment idx each SCAN cycle; after idx=N-1, SHALL go to DONE.
REQ-027 In DONE, SHALL hold rsp_vld=1 for exactly one cycle with rsp_filled and rsp_remaining=rem, then return to IDLE.
REQ-028 Outputs not named as active SHALL be 0; tbl_wr_* and fill_* SHALL be combinational from state and table inputs; rsp_* SHALL be registered.
REQ-029 The invariant rsp_filled + rsp_remaining == latched cmd_quantity SHALL hold.
REQ-030 An entry with quantity 0 that matches SHALL be invalidated with fill_quantity=0.

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL set state=IDLE, idx=0, rem=0 and filled=0.
REQ-032 Out of reset, all outputs SHALL be 0.
REQ-033 Reset mid-SCAN SHALL abort the command, with no rsp_vld and no further writes.

Configuration
REQ-034 Macro OB_TABLE_DRAIN_EARLY_EXIT_EN.
- Defined: SCAN SHALL go to DONE on the next cycle once rem reaches 0, or on the first valid entry that fails the price compare; latency is then variable.
- Undefined: SCAN SHALL always visit all N entries; fixed latency is command at cycle T, rsp_vld at T+N+1.

Verification
REQ-035 Test N=4, ask, entries {p100 q5, p101 q5, p102 q5, p103 q5} all valid, cmd p101 q7.
- Required: idx0 write inv, fill 5; idx1 write qty 3, fill 2; rsp filled 7, remaining 0; without the macro, rsp at T+5.
REQ-036 Same table, cmd p99 q10 -> no writes, no fills; rsp filled 0, remaining 10.
REQ-037 Same table, cmd p200 q50 -> all 4 entries invalidated; rsp filled 20, remaining 30.
REQ-038 Entry 1 invalid, cmd p103 q6 -> idx0 fill 5 inv; idx1 skipped; idx2 fill 1, qty 4; rsp filled 6.
REQ-039 cmd_vld pulsed during SCAN, then rst asserted at SCAN idx2 -> second command ignored, no rsp_vld, busy_w=0 the cycle after reset.
REQ-040 With OB_TABLE_DRAIN_EARLY_EXIT_EN, cmd p103 q5 -> rsp_vld at T+3; cmd p99 q10 -> rsp_vld at T+3.
